dev_bus_arbiter: RTL and testbench

- Two-master arbiter sharing one peripheral register bus: timer ctrl/preset/count slots at ADDR[3:2] = 00/01/10.
- M0 is the CPU data port; M1 is the config/debug master.
- Grants one single-word transaction at a time and returns a registered ack with read data.
- Optional bus lock for read-modify-write sequences, with a starvation guard.

---
 rtl/dev_bus_arbiter_if.sv | 55 +++++
 rtl/dev_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_dev_bus_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dev_bus_arbiter_if.sv
// dev_bus_arbiter_if
// Bundles both master ports and the shared device bus of dev_bus_arbiter.
//   M0_* / M1_* : per-master request, address [3:2], write enable, write data,
//                 lock, plus the arbiter's ack pulse and captured read data.
//   DEV_*       : single-word device strobe, address, write enable, write
//                 data and combinational read data.
//   GNT_O       : one-hot owner of the transfer in flight, 00 when idle.
// Modport 'slave' is the arbiter's view; 'master' is the masters/device view.
interface dev_bus_arbiter_if #(
  parameter int DW = 32
) ();
  logic          M0_REQ;
  logic [1:0]    M0_ADDR;
  logic          M0_WE;
  logic [DW-1:0] M0_DAT_I;
  logic          M0_LOCK;
  logic          M0_ACK;
  logic [DW-1:0] M0_DAT_O;

  logic          M1_REQ;
  logic [1:0]    M1_ADDR;
  logic          M1_WE;
  logic [DW-1:0] M1_DAT_I;
  logic          M1_LOCK;
  logic          M1_ACK;
  logic [DW-1:0] M1_DAT_O;

  logic          DEV_SEL_O;
  logic [1:0]    DEV_ADDR_O;
  logic          DEV_WE_O;
  logic [DW-1:0] DEV_DAT_O;
  logic [DW-1:0] DEV_DAT_I;

  logic [1:0]    GNT_O;

  modport slave (
    input  M0_REQ, M0_ADDR, M0_WE, M0_DAT_I, M0_LOCK,
    output M0_ACK, M0_DAT_O,
    input  M1_REQ, M1_ADDR, M1_WE, M1_DAT_I, M1_LOCK,
    output M1_ACK, M1_DAT_O,
    output DEV_SEL_O, DEV_ADDR_O, DEV_WE_O, DEV_DAT_O,
    input  DEV_DAT_I,
    output GNT_O
  );

  modport master (
    output M0_REQ, M0_ADDR, M0_WE, M0_DAT_I, M0_LOCK,
    input  M0_ACK, M0_DAT_O,
    output M1_REQ, M1_ADDR, M1_WE, M1_DAT_I, M1_LOCK,
    input  M1_ACK, M1_DAT_O,
    input  DEV_SEL_O, DEV_ADDR_O, DEV_WE_O, DEV_DAT_O,
    output DEV_DAT_I,
    input  GNT_O
  );
endinterface

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter
// Two-master arbiter for the timer register bus (ctrl/preset/count slots).
// One single-word transfer at a time: IDLE -> XFER (device strobed for one
// cycle, read data captured) -> ACK (one-cycle ack to the owner). A master
// holding LOCK keeps the bus across transfers, bounded by LOCK_MAX while the
// other master is waiting.
//   CLK_I : clock, rising edge
//   RST_I : synchronous active-low reset; also gates SEL/WE/GNT combinationally
//   bus   : dev_bus_arbiter_if.slave (master ports, device bus, GNT_O)
module dev_bus_arbiter #(
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input logic               CLK_I,
  input logic               RST_I,
  dev_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic [DW-1:0] m0_dat_q, m0_dat_d;
  logic [DW-1:0] m1_dat_q, m1_dat_d;

  logic          own_req, own_lock, own_we, oth_req;
  logic [1:0]    own_addr;
  logic [DW-1:0] own_dat;
  logic          arb_valid, arb_sel;
  logic          lock_limit;

  // Owner-side views of the master ports.
  assign own_req  = owner_q ? bus.M1_REQ   : bus.M0_REQ;
  assign own_lock = owner_q ? bus.M1_LOCK  : bus.M0_LOCK;
  assign own_we   = owner_q ? bus.M1_WE    : bus.M0_WE;
  assign own_addr = owner_q ? bus.M1_ADDR  : bus.M0_ADDR;
  assign own_dat  = owner_q ? bus.M1_DAT_I : bus.M0_DAT_I;
  assign oth_req  = owner_q ? bus.M0_REQ   : bus.M1_REQ;

  // The lock is refused once the waiting master has been passed over
  // LOCK_MAX-1 times in a row.
  assign lock_limit = oth_req && (lock_cnt_q == 4'(LOCK_MAX - 1));

  // Round-robin pick: a lone requester wins; on a tie the master that was
  // not served last wins.
  always_comb begin
    arb_valid = bus.M0_REQ | bus.M1_REQ;
    arb_sel   = 1'b0;
    if (bus.M0_REQ && bus.M1_REQ) begin
      arb_sel = ~last_q;
    end else if (bus.M1_REQ) begin
      arb_sel = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    m0_dat_d   = m0_dat_q;
    m1_dat_d   = m1_dat_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_sel;
          state_d = XFER;
        end
      end
      XFER: begin
        // Capture happens on the same edge that commits a write, so a read
        // sees the value the device presented before that edge.
        if (owner_q) begin
          m1_dat_d = bus.DEV_DAT_I;
        end else begin
          m0_dat_d = bus.DEV_DAT_I;
        end
        last_d  = owner_q;
        state_d = ACK;
      end
      ACK: begin
        if (own_lock && own_req && !lock_limit) begin
          state_d    = XFER;
          lock_cnt_d = oth_req ? (lock_cnt_q + 4'd1) : 4'd0;
        end else if (arb_valid) begin
          state_d    = XFER;
          owner_d    = arb_sel;
          lock_cnt_d = 4'd0;
        end else begin
          state_d    = IDLE;
          lock_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus-side outputs: the device only sees the owner during XFER, and reset
  // blocks any strobe or write from reaching it.
  always_comb begin
    bus.DEV_SEL_O  = 1'b0;
    bus.DEV_WE_O   = 1'b0;
    bus.DEV_ADDR_O = 2'b00;
    bus.DEV_DAT_O  = '0;
    bus.GNT_O      = 2'b00;
    if (state_q == XFER) begin
      bus.DEV_SEL_O  = RST_I;
      bus.DEV_WE_O   = RST_I & own_we;
      bus.DEV_ADDR_O = own_addr;
      bus.DEV_DAT_O  = own_dat;
    end
    if ((state_q != IDLE) && RST_I) begin
      bus.GNT_O = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Master-side outputs come straight from registered state.
  assign bus.M0_ACK   = (state_q == ACK) && !owner_q;
  assign bus.M1_ACK   = (state_q == ACK) &&  owner_q;
  assign bus.M0_DAT_O = m0_dat_q;
  assign bus.M1_DAT_O = m1_dat_q;

  // State register; last resets to M1 so M0 wins the first tie.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= 4'd0;
      m0_dat_q   <= '0;
      m1_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      m0_dat_q   <= m0_dat_d;
      m1_dat_q   <= m1_dat_d;
    end
  end

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// tb_dev_bus_arbiter
// Directed bench for dev_bus_arbiter with a transaction-level reference model
// that is compared against every output on every falling clock edge, plus
// hand-computed literal checks at the points of interest.
module tb_dev_bus_arbiter;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] dev_rdata;

  int tests_run;
  int tests_failed;

  dev_bus_arbiter_if #(.DW(DW)) bus ();

  assign bus.DEV_DAT_I = dev_rdata;

  dev_bus_arbiter #(.DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit m, input bit req, input bit we,
                               input bit lock, input logic [1:0] addr,
                               input logic [DW-1:0] dat);
    if (m) begin
      bus.M1_REQ = req; bus.M1_WE = we; bus.M1_LOCK = lock;
      bus.M1_ADDR = addr; bus.M1_DAT_I = dat;
    end else begin
      bus.M0_REQ = req; bus.M0_WE = we; bus.M0_LOCK = lock;
      bus.M0_ADDR = addr; bus.M0_DAT_I = dat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: which master is mid-transfer and in which half
  // (0 none, 1 on the device bus, 2 being acknowledged), who was served last,
  // how many times in a row a locked master has kept the bus against a
  // waiting rival, and the last word each master captured.
  int            m_phase;
  bit            m_who;
  bit            m_last;
  int            m_streak;
  logic [DW-1:0] m_dat [2];
  bit            m_valid;

  initial begin
    m_valid = 1'b0;
    m_phase = 0;
    m_who = 1'b0;
    m_last = 1'b1;
    m_streak = 0;
    m_dat[0] = '0;
    m_dat[1] = '0;
  end

  always @(negedge clk) begin
    bit            r [2];
    bit            l [2];
    bit            w [2];
    logic [1:0]    a [2];
    logic [DW-1:0] d [2];
    bit            any;
    bit            pick;
    bit            on_bus;
    r[0] = bus.M0_REQ;  r[1] = bus.M1_REQ;
    l[0] = bus.M0_LOCK; l[1] = bus.M1_LOCK;
    w[0] = bus.M0_WE;   w[1] = bus.M1_WE;
    a[0] = bus.M0_ADDR; a[1] = bus.M1_ADDR;
    d[0] = bus.M0_DAT_I; d[1] = bus.M1_DAT_I;
    on_bus = (m_phase == 1);

    if (m_valid) begin
      checkOutput("model_sel", bus.DEV_SEL_O, on_bus && rst_n);
      checkOutput("model_we", bus.DEV_WE_O, on_bus && rst_n && w[m_who]);
      checkOutput("model_addr", bus.DEV_ADDR_O, on_bus ? a[m_who] : 2'b00);
      checkOutput("model_wdat", bus.DEV_DAT_O, on_bus ? d[m_who] : '0);
      checkOutput("model_gnt", bus.GNT_O,
                  (m_phase != 0 && rst_n) ? (m_who ? 2'b10 : 2'b01) : 2'b00);
      checkOutput("model_ack0", bus.M0_ACK, m_phase == 2 && !m_who);
      checkOutput("model_ack1", bus.M1_ACK, m_phase == 2 && m_who);
      checkOutput("model_dat0", bus.M0_DAT_O, m_dat[0]);
      checkOutput("model_dat1", bus.M1_DAT_O, m_dat[1]);
    end

    // Decide what the coming rising edge does.
    any  = r[0] || r[1];
    pick = (r[0] && r[1]) ? !m_last : r[1];
    if (!rst_n) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_last = 1'b1;
      m_streak = 0;
      m_dat[0] = '0;
      m_dat[1] = '0;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        if (any) begin
          m_phase = 1;
          m_who = pick;
        end
      end else if (m_phase == 1) begin
        m_dat[m_who] = dev_rdata;
        m_last = m_who;
        m_phase = 2;
      end else begin
        if (l[m_who] && r[m_who] && !(r[!m_who] && m_streak == LOCK_MAX - 1)) begin
          m_phase = 1;
          m_streak = r[!m_who] ? m_streak + 1 : 0;
        end else begin
          m_streak = 0;
          if (any) begin
            m_phase = 1;
            m_who = (r[0] && r[1]) ? !m_who : r[1];
          end else begin
            m_phase = 0;
          end
        end
      end
    end
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    dev_rdata = 32'h1234;
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    applyStimulus(1, 0, 0, 0, 2'b00, '0);
    resetDut();

    // Single M0 write right after reset.
    applyStimulus(0, 1, 1, 0, 2'b01, 32'h10);
    @(negedge clk);
    checkOutput("rst_gnt", bus.GNT_O, 2'b00);
    checkOutput("rst_ack0", bus.M0_ACK, 1'b0);
    checkOutput("rst_dat0", bus.M0_DAT_O, 32'h0);
    checkOutput("rst_dat1", bus.M1_DAT_O, 32'h0);
    checkOutput("rst_sel", bus.DEV_SEL_O, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("wr_sel", bus.DEV_SEL_O, 1'b1);
    checkOutput("wr_we", bus.DEV_WE_O, 1'b1);
    checkOutput("wr_addr", bus.DEV_ADDR_O, 2'b01);
    checkOutput("wr_dat", bus.DEV_DAT_O, 32'h10);
    checkOutput("wr_gnt_xfer", bus.GNT_O, 2'b01);
    checkOutput("wr_noack", bus.M0_ACK, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("wr_ack", bus.M0_ACK, 1'b1);
    checkOutput("wr_sel_ack", bus.DEV_SEL_O, 1'b0);
    checkOutput("wr_we_ack", bus.DEV_WE_O, 1'b0);
    checkOutput("wr_gnt_ack", bus.GNT_O, 2'b01);
    tick();
    @(negedge clk);
    checkOutput("wr_idle_ack", bus.M0_ACK, 1'b0);
    checkOutput("wr_idle_gnt", bus.GNT_O, 2'b00);

    // Simultaneous reads in the first post-reset cycle.
    resetDut();
    applyStimulus(0, 1, 0, 0, 2'b10, '0);
    applyStimulus(1, 1, 0, 0, 2'b10, '0);
    dev_rdata = 32'h5;
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("tie_gnt_m0", bus.GNT_O, 2'b01);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    dev_rdata = 32'h4;
    @(negedge clk);
    checkOutput("tie_ack0", bus.M0_ACK, 1'b1);
    checkOutput("tie_dat0", bus.M0_DAT_O, 32'h5);
    checkOutput("tie_noack1", bus.M1_ACK, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("tie_gnt_m1", bus.GNT_O, 2'b10);
    checkOutput("tie_sel_m1", bus.DEV_SEL_O, 1'b1);
    tick();
    applyStimulus(1, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("tie_ack1", bus.M1_ACK, 1'b1);
    checkOutput("tie_dat1", bus.M1_DAT_O, 32'h4);
    checkOutput("tie_dat0_hold", bus.M0_DAT_O, 32'h5);

    // Continuous requests without lock: strict alternation.
    tick();
    applyStimulus(0, 1, 0, 0, 2'b00, '0);
    applyStimulus(1, 1, 0, 0, 2'b01, '0);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 15) begin
        applyStimulus(0, 0, 0, 0, 2'b00, '0);
        applyStimulus(1, 0, 0, 0, 2'b00, '0);
      end
      @(negedge clk);
      checkOutput($sformatf("alt_ack0_%0d", k), bus.M0_ACK, (k % 4) == 1);
      checkOutput($sformatf("alt_ack1_%0d", k), bus.M1_ACK, (k % 4) == 3);
    end

    // M0 locked against a waiting M1, then locked with M1 idle.
    tick();
    dev_rdata = 32'h77;
    applyStimulus(0, 1, 0, 1, 2'b10, '0);
    applyStimulus(1, 1, 0, 0, 2'b10, '0);
    for (int k = 0; k < 34; k++) begin
      tick();
      if (k == 9) applyStimulus(1, 0, 0, 0, 2'b00, '0);
      if (k == 33) applyStimulus(0, 0, 0, 0, 2'b00, '0);
      @(negedge clk);
      checkOutput($sformatf("lock_ack0_%0d", k), bus.M0_ACK, (k % 2 == 1) && (k != 9));
      checkOutput($sformatf("lock_ack1_%0d", k), bus.M1_ACK, k == 9);
    end

    // Reset landing in the XFER cycle of an M1 write.
    tick();
    applyStimulus(1, 1, 1, 0, 2'b00, 32'hABCD);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rx_sel", bus.DEV_SEL_O, 1'b0);
    checkOutput("rx_we", bus.DEV_WE_O, 1'b0);
    checkOutput("rx_gnt", bus.GNT_O, 2'b00);
    checkOutput("rx_ack1", bus.M1_ACK, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 1, 0, 0, 2'b01, '0);
    applyStimulus(1, 1, 0, 0, 2'b01, '0);
    @(negedge clk);
    checkOutput("rx_idle_gnt", bus.GNT_O, 2'b00);
    checkOutput("rx_idle_ack0", bus.M0_ACK, 1'b0);
    checkOutput("rx_idle_ack1", bus.M1_ACK, 1'b0);
    checkOutput("rx_dat0", bus.M0_DAT_O, 32'h0);
    checkOutput("rx_dat1", bus.M1_DAT_O, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("rx_tie_m0", bus.GNT_O, 2'b01);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("rx_ack0", bus.M0_ACK, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("rx_then_m1", bus.GNT_O, 2'b10);
    tick();
    applyStimulus(1, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("rx_ack1_after", bus.M1_ACK, 1'b1);

    // Read of the unused slot with read data changing after the capture edge.
    tick();
    dev_rdata = 32'hCAFE;
    applyStimulus(0, 1, 0, 0, 2'b11, '0);
    tick();
    @(negedge clk);
    checkOutput("slot3_addr", bus.DEV_ADDR_O, 2'b11);
    checkOutput("slot3_sel", bus.DEV_SEL_O, 1'b1);
    tick();
    dev_rdata = 32'hBEEF;
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    @(negedge clk);
    checkOutput("cap_ack0", bus.M0_ACK, 1'b1);
    checkOutput("cap_dat0", bus.M0_DAT_O, 32'hCAFE);
    tick();
    @(negedge clk);
    checkOutput("cap_dat0_hold", bus.M0_DAT_O, 32'hCAFE);
    checkOutput("cap_idle_gnt", bus.GNT_O, 2'b00);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
